// File: rtl/hv_binarizer.sv
// hv_binarizer: thresholds M_SIZE encoded dimensions per beat into a packed Dhv_SIZE-bit binary hypervector.
// Define HV_POPCOUNT_EN to add the out_popcount port with its running ones count.
module hv_binarizer #(
    parameter int          Dhv_SIZE  = 4000,
    parameter int          M_SIZE    = 16,
    parameter int          DIM_WIDTH = 16,
    parameter int unsigned THRESH    = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [M_SIZE-1:0][DIM_WIDTH-1:0] in_dims,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             clear,
    output logic [Dhv_SIZE-1:0]              out_hv,
    output logic                             out_valid,
    input  logic                             out_ready
`ifdef HV_POPCOUNT_EN
    ,
    output logic [$clog2(Dhv_SIZE+1)-1:0]    out_popcount
`endif
);

    localparam int                   NUM_CHUNKS = Dhv_SIZE / M_SIZE;
    localparam int                   IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [DIM_WIDTH-1:0] THRESH_V   = DIM_WIDTH'(THRESH);

    if ((Dhv_SIZE % M_SIZE) != 0) begin : g_size_check
        $error("hv_binarizer: Dhv_SIZE must be an exact multiple of M_SIZE");
    end

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [IDX_W-1:0]    idx;
    logic [Dhv_SIZE-1:0] hv_q;
    logic [M_SIZE-1:0]   chunk_bits;
    logic                accept;
    logic                at_last;
    logic                release_hv;

    assign accept     = in_valid && in_ready;
    assign at_last    = (idx == LAST_IDX);
    assign release_hv = (state == HOLD) && out_ready;
    assign out_hv     = hv_q;

    always_comb begin
        chunk_bits = '0;
        for (int j = 0; j < M_SIZE; j++) begin
            chunk_bits[j] = (in_dims[j] > THRESH_V);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // clear wins over both the final accept and the output handshake
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = FILL;
        end else begin
            case (state)
                FILL:    if (accept && at_last) state_next = HOLD;
                HOLD:    if (out_ready)         state_next = FILL;
                default:                        state_next = FILL;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == FILL);
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (accept) begin
            idx <= at_last ? '0 : idx + 1'b1;
        end
    end

    // Each chunk slot is written through a constant-base slice selected by idx
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hv_q <= '0;
        end else if (clear) begin
            hv_q <= '0;
        end else if (accept) begin
            for (int k = 0; k < NUM_CHUNKS; k++) begin
                if (idx == IDX_W'(k)) begin
                    hv_q[k*M_SIZE +: M_SIZE] <= chunk_bits;
                end
            end
        end
    end

`ifdef HV_POPCOUNT_EN
    localparam int PC_W = $clog2(Dhv_SIZE + 1);

    logic [PC_W-1:0] chunk_ones;
    logic [PC_W-1:0] pc_q;

    always_comb begin
        chunk_ones = '0;
        for (int j = 0; j < M_SIZE; j++) begin
            chunk_ones = chunk_ones + PC_W'(chunk_bits[j]);
        end
    end

    // Running count restarts whenever a new vector begins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else if (clear || release_hv) begin
            pc_q <= '0;
        end else if (accept) begin
            pc_q <= pc_q + chunk_ones;
        end
    end

    assign out_popcount = pc_q;
`else
    logic unused_release;
    assign unused_release = release_hv;
`endif

endmodule

// File: tb/tb_hv_binarizer.sv
// tb_hv_binarizer: randomized self-checking bench comparing two hv_binarizer instances (THRESH 0 and 5)
// against a per-bit reference built from the stored chunk values.
module tb_hv_binarizer;

    localparam int D = 4000;
    localparam int M = 16;
    localparam int W = 16;
    localparam int N = D / M;

    logic                clk = 1'b0;
    logic                reset;
    logic [M-1:0][W-1:0] in_dims;
    logic                in_valid;
    logic                clear;
    logic                out_ready;
    logic                in_ready0, in_ready5;
    logic                out_valid0, out_valid5;
    logic [D-1:0]        out_hv0, out_hv5;
`ifdef HV_POPCOUNT_EN
    logic [11:0]         pc0, pc5;
`endif

    logic [W-1:0] chunk_mem [0:N-1][0:M-1];
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hv_binarizer #(.Dhv_SIZE(D), .M_SIZE(M), .DIM_WIDTH(W), .THRESH(0)) dut0 (
        .clk(clk), .reset(reset), .in_dims(in_dims), .in_valid(in_valid),
        .in_ready(in_ready0), .clear(clear), .out_hv(out_hv0),
        .out_valid(out_valid0), .out_ready(out_ready)
`ifdef HV_POPCOUNT_EN
        , .out_popcount(pc0)
`endif
    );

    hv_binarizer #(.Dhv_SIZE(D), .M_SIZE(M), .DIM_WIDTH(W), .THRESH(5)) dut5 (
        .clk(clk), .reset(reset), .in_dims(in_dims), .in_valid(in_valid),
        .in_ready(in_ready5), .clear(clear), .out_hv(out_hv5),
        .out_valid(out_valid5), .out_ready(out_ready)
`ifdef HV_POPCOUNT_EN
        , .out_popcount(pc5)
`endif
    );

    // Reference: bit i of the vector is lane i%M of chunk i/M compared against the threshold
    function automatic logic [D-1:0] expected_hv(input int unsigned thresh);
        logic [D-1:0] e;
        for (int i = 0; i < D; i++) e[i] = (int'(chunk_mem[i/M][i%M]) > int'(thresh));
        return e;
    endfunction

    function automatic int count_ones(input logic [D-1:0] v);
        int c = 0;
        for (int i = 0; i < D; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int first_diff(input logic [D-1:0] a, input logic [D-1:0] b);
        for (int i = 0; i < D; i++) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    // mode 0 random mix of 0 and 1..10, 1 all ones, 2 (k+j)%2, 3 lanes alternating 5/6
    task automatic fill_chunks(input int mode);
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < M; j++) begin
                case (mode)
                    1:       chunk_mem[k][j] = 16'd1;
                    2:       chunk_mem[k][j] = 16'((k + j) % 2);
                    3:       chunk_mem[k][j] = (j % 2 == 0) ? 16'd5 : 16'd6;
                    default: chunk_mem[k][j] = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 10));
                endcase
            end
        end
    endtask

    task automatic randomize_dims();
        for (int j = 0; j < M; j++) in_dims[j] = 16'($urandom);
    endtask

    // Presents chunks 0..n-1; bad flags in_ready low or out_valid high while filling
    task automatic drive_beats(input int n, input bit gaps, output bit bad);
        int idle;
        bad = 1'b0;
        for (int k = 0; k < n; k++) begin
            idle = gaps ? $urandom_range(0, 2) : 0;
            for (int g = 0; g < idle; g++) begin
                in_valid = 1'b0;
                randomize_dims();
                @(posedge clk); #1;
                if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) bad = 1'b1;
            end
            in_valid = 1'b1;
            for (int j = 0; j < M; j++) in_dims[j] = chunk_mem[k][j];
            if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0; in_dims = '0;
        #12;
        total++; if (out_valid0 !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", out_valid0); else passed++;
        total++; if (in_ready0 !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", in_ready0); else passed++;
        total++; if (out_hv0 !== '0) $display("[TB] FAIL reset_hv: got %0d ones want 0", $countones(out_hv0)); else passed++;
`ifdef HV_POPCOUNT_EN
        total++; if (pc0 !== 12'd0) $display("[TB] FAIL reset_popcount: got %0d want 0", pc0); else passed++;
`endif
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_all_ones();
        bit bad;
        logic [D-1:0] exp0;
        fill_chunks(1);
        exp0 = expected_hv(0);
        out_ready = 1'b1;
        drive_beats(N, 1'b0, bad);
        total++; if (bad) $display("[TB] FAIL ones_fill: handshake wrong during fill, got bad=1 want 0"); else passed++;
        total++; if (out_valid0 !== 1'b1) $display("[TB] FAIL ones_valid: got %b want 1", out_valid0); else passed++;
        total++; if (out_hv0 !== exp0) $display("[TB] FAIL ones_hv: first diff bit %0d, got %0d ones want %0d", first_diff(out_hv0, exp0), $countones(out_hv0), D); else passed++;
`ifdef HV_POPCOUNT_EN
        total++; if (pc0 !== 12'd4000) $display("[TB] FAIL ones_popcount: got %0d want 4000", pc0); else passed++;
`endif
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) $display("[TB] FAIL ones_release: got valid=%b ready=%b want 0/1", out_valid0, in_ready0); else passed++;
    endtask

    task automatic test_alternating();
        bit bad;
        logic [D-1:0] exp0;
        fill_chunks(2);
        exp0 = expected_hv(0);
        drive_beats(N, 1'b1, bad);
        total++; if (bad) $display("[TB] FAIL alt_fill: handshake wrong during fill, got bad=1 want 0"); else passed++;
        total++; if (out_hv0 !== exp0) $display("[TB] FAIL alt_hv: first diff bit %0d, got %0d ones want %0d", first_diff(out_hv0, exp0), $countones(out_hv0), count_ones(exp0)); else passed++;
`ifdef HV_POPCOUNT_EN
        total++; if (pc0 !== 12'd2000) $display("[TB] FAIL alt_popcount: got %0d want 2000", pc0); else passed++;
`endif
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        total++; if (out_valid0 !== 1'b0) $display("[TB] FAIL alt_release: got %b want 0", out_valid0); else passed++;
    endtask

    task automatic test_thresh();
        bit bad;
        logic [D-1:0] exp5;
        logic [D-1:0] pattern;
        fill_chunks(3);
        exp5 = expected_hv(5);
        pattern = {(D/2){2'b10}};
        drive_beats(N, 1'b0, bad);
        total++; if (out_valid5 !== 1'b1 || in_ready5 !== 1'b0) $display("[TB] FAIL thresh_state: got valid=%b ready=%b want 1/0", out_valid5, in_ready5); else passed++;
        total++; if (out_hv5 !== exp5) $display("[TB] FAIL thresh_hv_model: first diff bit %0d, got %0d ones want %0d", first_diff(out_hv5, exp5), $countones(out_hv5), count_ones(exp5)); else passed++;
        total++; if (out_hv5 !== pattern) $display("[TB] FAIL thresh_hv_pattern: first diff bit %0d, got %0d ones want %0d", first_diff(out_hv5, pattern), $countones(out_hv5), D/2); else passed++;
        total++; if (out_hv0 !== {D{1'b1}}) $display("[TB] FAIL thresh0_hv: got %0d ones want %0d", $countones(out_hv0), D); else passed++;
`ifdef HV_POPCOUNT_EN
        total++; if (pc5 !== 12'd2000) $display("[TB] FAIL thresh_popcount: got %0d want 2000", pc5); else passed++;
`endif
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit bad;
        bit held_bad;
        logic [D-1:0] exp0;
        fill_chunks(0);
        exp0 = expected_hv(0);
        drive_beats(N, 1'b0, bad);
        held_bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1; randomize_dims(); out_ready = 1'b0;
            @(posedge clk); #1;
            if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || out_hv0 !== exp0) held_bad = 1'b1;
        end
        total++; if (held_bad) $display("[TB] FAIL bp_hold: output disturbed while stalled, got bad=1 want 0"); else passed++;
        out_ready = 1'b1; in_valid = 1'b1; randomize_dims();
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        total++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) $display("[TB] FAIL bp_release: got valid=%b ready=%b want 0/1", out_valid0, in_ready0); else passed++;
        fill_chunks(0);
        exp0 = expected_hv(0);
        drive_beats(N, 1'b0, bad);
        total++; if (bad || out_valid0 !== 1'b1) $display("[TB] FAIL bp_next_valid: got bad=%b valid=%b want 0/1", bad, out_valid0); else passed++;
        total++; if (out_hv0 !== exp0) $display("[TB] FAIL bp_next_hv: first diff bit %0d, got %0d ones want %0d", first_diff(out_hv0, exp0), $countones(out_hv0), count_ones(exp0)); else passed++;
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_clear();
        bit bad;
        logic [D-1:0] exp0;
        fill_chunks(0);
        drive_beats(100, 1'b1, bad);
        clear = 1'b1; in_valid = 1'b1;
        for (int j = 0; j < M; j++) in_dims[j] = 16'hFFFF;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        total++; if (out_hv0 !== '0) $display("[TB] FAIL clear_hv: got %0d ones want 0", $countones(out_hv0)); else passed++;
        total++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) $display("[TB] FAIL clear_state: got valid=%b ready=%b want 0/1", out_valid0, in_ready0); else passed++;
`ifdef HV_POPCOUNT_EN
        total++; if (pc0 !== 12'd0) $display("[TB] FAIL clear_popcount: got %0d want 0", pc0); else passed++;
`endif
        fill_chunks(0);
        exp0 = expected_hv(0);
        drive_beats(N, 1'b0, bad);
        total++; if (out_hv0 !== exp0 || out_valid0 !== 1'b1) $display("[TB] FAIL clear_next_hv: first diff bit %0d, valid=%b want valid 1", first_diff(out_hv0, exp0), out_valid0); else passed++;
        clear = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; out_ready = 1'b0;
        total++; if (out_valid0 !== 1'b0 || out_hv0 !== '0) $display("[TB] FAIL clear_hold: got valid=%b ones=%0d want 0/0", out_valid0, $countones(out_hv0)); else passed++;
    endtask

    task automatic test_reset_mid();
        bit bad;
        logic [D-1:0] exp0;
        fill_chunks(0);
        drive_beats(50, 1'b0, bad);
        #2; reset = 1'b0; #1;
        total++; if (out_hv0 !== '0 || out_valid0 !== 1'b0 || in_ready0 !== 1'b1) $display("[TB] FAIL rst_mid: got ones=%0d valid=%b ready=%b want 0/0/1", $countones(out_hv0), out_valid0, in_ready0); else passed++;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        fill_chunks(0);
        exp0 = expected_hv(0);
        drive_beats(N, 1'b0, bad);
        total++; if (out_hv0 !== exp0 || out_valid0 !== 1'b1) $display("[TB] FAIL rst_next_hv: first diff bit %0d, valid=%b want valid 1", first_diff(out_hv0, exp0), out_valid0); else passed++;
        #2; reset = 1'b0; #1;
        total++; if (out_hv0 !== '0 || out_valid0 !== 1'b0 || in_ready0 !== 1'b1) $display("[TB] FAIL rst_hold: got ones=%0d valid=%b ready=%b want 0/0/1", $countones(out_hv0), out_valid0, in_ready0); else passed++;
`ifdef HV_POPCOUNT_EN
        total++; if (pc0 !== 12'd0) $display("[TB] FAIL rst_popcount: got %0d want 0", pc0); else passed++;
`endif
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random_vectors();
        bit bad;
        bit wait_bad;
        int delay;
        logic [D-1:0] exp0;
        logic [D-1:0] exp5;
        for (int v = 0; v < 3; v++) begin
            fill_chunks(0);
            exp0 = expected_hv(0);
            exp5 = expected_hv(5);
            drive_beats(N, 1'b1, bad);
            total++; if (bad) $display("[TB] FAIL rand_fill_%0d: handshake wrong during fill, got bad=1 want 0", v); else passed++;
            total++; if (out_hv0 !== exp0 || out_hv5 !== exp5) $display("[TB] FAIL rand_hv_%0d: diff t0 bit %0d, diff t5 bit %0d, want -1/-1", v, first_diff(out_hv0, exp0), first_diff(out_hv5, exp5)); else passed++;
            delay = $urandom_range(0, 5);
            wait_bad = 1'b0;
            for (int c = 0; c < delay; c++) begin
                @(posedge clk); #1;
                if (out_valid0 !== 1'b1 || out_hv5 !== exp5) wait_bad = 1'b1;
            end
            out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
            total++; if (wait_bad || out_valid0 !== 1'b0) $display("[TB] FAIL rand_release_%0d: got bad=%b valid=%b want 0/0", v, wait_bad, out_valid0); else passed++;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_all_ones();
        test_alternating();
        test_thresh();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_random_vectors();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hv_binarizer.md
HV_BINARIZER -- requirements
Module: hv_binarizer

Interface
REQ-001 SHALL have parameter Dhv_SIZE, default 4000, hypervector length in bits; must be an exact multiple of M_SIZE.
REQ-002 SHALL have parameter M_SIZE, default 16, encoded dimensions accepted per input beat.
REQ-003 SHALL have parameter DIM_WIDTH, default 16, unsigned width of each encoded dimension.
REQ-004 SHALL have parameter THRESH, default 0, unsigned binarization threshold.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_dims  input  [M_SIZE-1:0][DIM_WIDTH-1:0]  one chunk of encoded dimensions from the encoding stage.
REQ-008 SHALL have port in_valid  input  1  in_dims valid this cycle.
REQ-009 SHALL have port in_ready  output  1  block accepts a chunk this cycle.
REQ-010 SHALL have port clear  input  1  synchronous abort of the vector being assembled.
REQ-011 SHALL have port out_hv  output  [Dhv_SIZE-1:0]  packed binary hypervector.
REQ-012 SHALL have port out_valid  output  1  out_hv complete and stable.
REQ-013 SHALL have port out_ready  input  1  consumer takes out_hv.
REQ-014 SHALL have port out_popcount  output  [$clog2(Dhv_SIZE+1)-1:0]  number of ones in out_hv; present only when HV_POPCOUNT_EN is defined.

Function
REQ-015 SHALL implement two states: FILL and HOLD.
REQ-016 SHALL keep chunk index idx, range 0..Dhv_SIZE/M_SIZE-1, of width $clog2(Dhv_SIZE/M_SIZE).
REQ-017 SHALL drive in_ready=1 in FILL and 0 in HOLD, decoded from the state register only.
REQ-018 SHALL accept a chunk when in_valid && in_ready.
REQ-019 SHALL, on accept, register bit (in_dims[j] > THRESH), unsigned compare, into out_hv[idx*M_SIZE+j] for j=0..M_SIZE-1, and leave all other bits unchanged.
REQ-020 SHALL increment idx on each accept while idx < last.
REQ-021 SHALL, on accept at idx = last, set idx to 0 and enter HOLD; out_valid rises the next cycle, one cycle after the final accept.
REQ-022 SHALL, in HOLD, assert out_valid and hold out_hv (and out_popcount) stable until out_ready is sampled high.
REQ-023 SHALL, on out_valid && out_ready, return to FILL next cycle with out_valid=0; no chunk is accepted in that handshake cycle.
REQ-024 SHALL keep out_valid=0 throughout FILL; partial out_hv contents are don't-care to the consumer.
REQ-025 SHALL, when clear=1, return to FILL, idx=0, zero out_hv and out_popcount, and deassert out_valid next cycle, regardless of state.
REQ-026 SHALL give clear priority over a simultaneous accept (chunk discarded) and over a simultaneous out handshake.
REQ-027 SHALL ignore in_dims and in_valid in HOLD.
REQ-028 SHALL ignore out_ready in FILL.

Reset
REQ-029 SHALL, while reset=0, asynchronously force state=FILL, idx=0, out_hv=0, out_valid=0, out_popcount=0; in_ready=1 follows from FILL.
REQ-030 SHALL treat reset asserted mid-vector as discarding all partial data; assembly restarts at idx 0 after release.

Configuration
REQ-031 SHALL compile in out_popcount and its logic only when macro HV_POPCOUNT_EN is defined; without it, the port and logic are absent and all other behaviour is identical.
REQ-032 SHALL, with HV_POPCOUNT_EN, maintain out_popcount incrementally: add the chunk's ones count on each accept; clear it to 0 on entering FILL from HOLD, on clear, and on reset. In HOLD it equals the popcount of out_hv.

Verification
REQ-033 SHALL cover: defaults, all in_dims=1, 250 consecutive beats, out_ready=1 -> out_valid one cycle after beat 250, out_hv all ones, out_popcount=4000.
REQ-034 SHALL cover: chunk k, lane j holding value (k+j)%2 -> out_hv[16k+j]=(k+j)%2, out_popcount=2000.
REQ-035 SHALL cover: THRESH=5, in_dims = 5 or 6 on alternate lanes -> out_hv bits alternate 0,1 (value 5 maps to 0).
REQ-036 SHALL cover: out_ready held 0 for 20 cycles after completion, with in_valid=1 -> in_ready=0, out_hv stable, no chunk consumed; the handshake then returns to FILL with idx=0.
REQ-037 SHALL cover: clear asserted after 100 beats, together with in_valid -> that chunk dropped, out_hv=0; a following full 250 beats complete normally.
REQ-038 SHALL cover: reset pulsed low mid-vector and in HOLD -> outputs immediately 0, in_ready=1, next vector assembles from idx 0.
